// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall/flush control for load-use, branches, multi-cycle ops and memory waits
module hazard_controller #(
    parameter int MUL_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memread,
    input  logic        ex_branch_taken,
    input  logic        ex_is_mul,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        mul_start,
    output logic        state,
    output logic [31:0] stall_cycles
);
    typedef enum logic {RUN = 1'b0, MUL_WAIT = 1'b1} state_t;
    state_t      state_q, state_d;
    logic [3:0]  mul_cnt_q, mul_cnt_d;
    logic [31:0] stall_q, stall_d;
    logic        mem_stall, mul_go, mul_hold, adv, load_use, br, lu;
    always_comb begin
        mem_stall   = mem_req & ~mem_ready;
        mul_go      = ~mem_stall & (state_q == RUN) & ex_is_mul;
        mul_hold    = ~mem_stall & (state_q == MUL_WAIT) & (mul_cnt_q != 4'd0);
        adv         = ~mem_stall & ~mul_go & ~mul_hold;
        load_use    = ex_memread & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
        br          = adv & ex_branch_taken;
        lu          = adv & ~ex_branch_taken & load_use;
        pc_en       = adv & ~lu;
        ifid_en     = adv & ~lu;
        idex_en     = adv;
        exmem_en    = ~mem_stall;
        ifid_flush  = br;
        idex_flush  = br | lu;
        exmem_flush = mul_go | mul_hold;
        mul_start   = mul_go & rst_n;
        state_d     = mem_stall ? state_q : (mul_go | mul_hold) ? MUL_WAIT : RUN;
        // counter keeps draining during memory stalls so the release lands on the first ready cycle
        mul_cnt_d   = mul_go ? 4'(MUL_LATENCY - 2) : (mul_cnt_q != 4'd0) ? mul_cnt_q - 4'd1 : 4'd0;
        stall_d     = (~pc_en & ~&stall_q) ? stall_q + 32'd1 : stall_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            mul_cnt_q <= 4'd0;
            stall_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            stall_q   <= stall_d;
        end
    end
    assign state        = state_q;
    assign stall_cycles = stall_q;
endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 4: cycles a multi-cycle op occupies EX, counting its first EX cycle; legal range 2..15.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source.
- ex_rd  in  5  destination of the instruction in EX.
- ex_memread  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- ex_is_mul  in  1  EX holds a multi-cycle (mul/div) op.
- mem_req  in  1  MEM instruction is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  register load enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  insert bubble into that register.
- mul_start  out  1  one-cycle start pulse to the multi-cycle unit.
- state  out  1  0 = RUN, 1 = MUL_WAIT.
- stall_cycles  out  32  performance counter.

Function
REQ-003 SHALL implement two states, RUN and MUL_WAIT, plus a 4-bit down-counter mul_cnt.
REQ-004 SHALL define mem_stall = mem_req & ~mem_ready, evaluated combinationally in every state.
REQ-005 While mem_stall=1, SHALL drive pc_en=ifid_en=idex_en=exmem_en=0 and all flushes 0. This has highest priority.
REQ-006 While mem_stall=1, state SHALL NOT change, except that mul_cnt continues decrementing, saturating at 0.
REQ-007 In RUN with ex_is_mul=1 and mem_stall=0, SHALL:
- pulse mul_start=1;
- drive pc_en=ifid_en=idex_en=0, exmem_en=1, exmem_flush=1;
- load mul_cnt=MUL_LATENCY-2;
- go to MUL_WAIT.
REQ-008 In MUL_WAIT with mul_cnt!=0 and mem_stall=0, SHALL apply the REQ-007 enables and flushes with mul_start=0, and decrement mul_cnt.
REQ-009 In MUL_WAIT with mul_cnt=0 and mem_stall=0 (release cycle), SHALL drive outputs per REQ-010..012 as RUN, but SHALL NOT start a new op, and SHALL go to RUN. The op thus occupies EX exactly MUL_LATENCY cycles.
REQ-010 Default advancing outputs SHALL be: all enables 1, all flushes 0, mul_start 0.
REQ-011 When advancing and ex_branch_taken=1, SHALL assert ifid_flush=1 and idex_flush=1, and SHALL suppress load-use detection that cycle.
REQ-012 When advancing, ex_branch_taken=0, and ex_memread=1, ex_rd!=0, and ex_rd matches a used ID source, SHALL drive pc_en=0, ifid_en=0, idex_flush=1 (one-cycle load-use bubble).
REQ-013 ex_branch_taken and load-use SHALL be ignored in any cycle that is not advancing (mem_stall, or MUL_WAIT with mul_cnt!=0).
REQ-014 ex_branch_taken and ex_is_mul both 1 in RUN SHALL be treated as ex_is_mul (mul priority).
REQ-015 stall_cycles SHALL increment by 1 on every clock with pc_en=0, saturating at 0xFFFF_FFFF.
REQ-016 All outputs except state and stall_cycles SHALL be combinational from inputs, state and mul_cnt, with no added latency.

Reset
REQ-017 rst_n=0 SHALL immediately force state=RUN, mul_cnt=0, stall_cycles=0, regardless of clk.
REQ-018 During reset, outputs SHALL follow the RUN rules from the current inputs, except that mul_start SHALL be forced to 0.
REQ-019 A reset asserted mid-MUL_WAIT SHALL abandon the op; no release cycle occurs.
REQ-020 The first clock after rst_n rises SHALL be evaluated as RUN.

Verification
REQ-021 Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cycles=1.
REQ-022 ex_rd=0 with all other REQ-021 inputs unchanged -> no stall; ex_rd=5 but id_uses_rs2=0 -> no stall.
REQ-023 MUL_LATENCY=4, ex_is_mul=1 held -> mul_start high only in cycle 0; pc_en=0 for cycles 0-2; release in cycle 3; state returns to RUN; stall_cycles=3.
REQ-024 mem_req=1, mem_ready=0 for 5 cycles during MUL_WAIT at mul_cnt=1 -> all enables 0; mul_cnt reaches 0 and holds; release occurs on the first cycle with mem_ready=1.
REQ-025 ex_branch_taken=1 together with a REQ-021 load-use match -> ifid_flush=1, idex_flush=1, pc_en=1.
REQ-026 rst_n dropped mid-MUL_WAIT -> state=0 and stall_cycles=0 without a clock edge; after release with ex_is_mul=1, mul_start pulses again.
